// File: rtl/id_issue_stage_pkg.sv
// Shared definitions for the ID/issue stage: IF->ID register width, stall bus
// encoding, buffer states and the priority forward-merge helper.
package id_issue_stage_pkg;

    localparam int IF_TO_ID_WD = 33;  // {ce, pc}

    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_HELD  = 1'b1
    } buf_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
        logic        load;
    } fwd_res_t;

    // Scanning from oldest to youngest, a younger match overrides the result so far.
    function automatic fwd_res_t fwd_merge(
        input fwd_res_t    older,
        input logic        match,
        input logic [31:0] data,
        input logic        load
    );
        fwd_res_t r;
        r = older;
        if (match) begin
            r.data = data;
            r.hit  = 1'b1;
            r.load = load;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_issue_stage_fwd_sel.sv
// Priority forwarding mux: lowest-index matching source wins, r0 reads as zero.
module fwd_sel
    import id_issue_stage_pkg::*;
#(
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]            addr,
    input  logic [31:0]           rf_rdata,
    input  logic [NUM_FWD-1:0]    fwd_we,
    input  logic [5*NUM_FWD-1:0]  fwd_waddr,
    input  logic [32*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]    fwd_is_load,
    output logic [31:0]           data,
    output logic                  hit,
    output logic                  load
);

    logic [NUM_FWD-1:0] match;
    fwd_res_t           res;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_we[gi] && (fwd_waddr[5*gi +: 5] == addr);
        end
    endgenerate

    always_comb begin
        res = '{data: rf_rdata, hit: 1'b0, load: 1'b0};
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            res = fwd_merge(res, match[k], fwd_wdata[32*k +: 32], fwd_is_load[k]);
        end
        if (addr == 5'd0) begin
            res = '0;
        end
    end

    assign data = res.data;
    assign hit  = res.hit;
    assign load = res.load;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue front end: IF->ID register, stall-safe instruction buffer,
// operand forwarding, load-use interlock and saturating interlock counter.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  if_ce,
    input  logic [31:0]           if_pc,
    input  logic [31:0]           inst_sram_rdata,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic [31:0]           rf_rdata1,
    input  logic [31:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]    fwd_we,
    input  logic [5*NUM_FWD-1:0]  fwd_waddr,
    input  logic [32*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]    fwd_is_load,
    output logic                  id_ce,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_inst,
    output logic [4:0]            rs_addr,
    output logic [4:0]            rt_addr,
    output logic [31:0]           rs_val,
    output logic [31:0]           rt_val,
    output logic                  stallreq,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [IF_TO_ID_WD-1:0] if_id_q, if_id_d;
    buf_state_e             state_q, state_d;
    logic [31:0]            inst_buf_q, inst_buf_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic hit_rs, load_rs, hit_rt, load_rt;
    logic unused_stall_bits;

    assign unused_stall_bits = ^{stall[STALL_W-1:STALL_ID+1], stall[0]};

    assign id_ce = if_id_q[IF_TO_ID_WD-1];
    assign id_pc = if_id_q[31:0];

    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d = '0;
        end else if (stall[STALL_IF] == Stop && stall[STALL_ID] == NoStop) begin
            if_id_d = '0;
        end else if (stall[STALL_IF] == NoStop) begin
            if_id_d = {if_ce, if_pc};
        end
    end

    // The SRAM only presents its word for one cycle, so a stalled ID must keep a copy.
    always_comb begin
        state_d    = state_q;
        inst_buf_d = inst_buf_q;
        if (flush) begin
            state_d    = BUF_EMPTY;
            inst_buf_d = '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (stall[STALL_ID] == Stop && id_ce) begin
                        state_d    = BUF_HELD;
                        inst_buf_d = inst_sram_rdata;
                    end
                end
                BUF_HELD: begin
                    if (stall[STALL_ID] == NoStop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        id_inst = '0;
        if (id_ce) begin
            id_inst = (state_q == BUF_HELD) ? inst_buf_q : inst_sram_rdata;
        end
    end

    assign rs_addr = id_inst[25:21];
    assign rt_addr = id_inst[20:16];

    fwd_sel #(.NUM_FWD(NUM_FWD)) u_fwd_rs (
        .addr        (rs_addr),
        .rf_rdata    (rf_rdata1),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_is_load (fwd_is_load),
        .data        (rs_val),
        .hit         (hit_rs),
        .load        (load_rs)
    );

    fwd_sel #(.NUM_FWD(NUM_FWD)) u_fwd_rt (
        .addr        (rt_addr),
        .rf_rdata    (rf_rdata2),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_is_load (fwd_is_load),
        .data        (rt_val),
        .hit         (hit_rt),
        .load        (load_rt)
    );

    assign stallreq = id_ce & ((use_rs & hit_rs & load_rs) | (use_rt & hit_rt & load_rt));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallreq && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_q     <= '0;
            state_q     <= BUF_EMPTY;
            inst_buf_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if_id_q     <= if_id_d;
            state_q     <= state_d;
            inst_buf_q  <= inst_buf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: pipeline flow, forwarding, interlock,
// buffer hold/flush, counter saturation and asynchronous reset.
module tb_id_issue_stage;

    localparam int NUM_FWD = 3;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic                  if_ce;
    logic [31:0]           if_pc;
    logic [31:0]           inst_sram_rdata;
    logic                  use_rs, use_rt;
    logic [31:0]           rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]    fwd_we;
    logic [5*NUM_FWD-1:0]  fwd_waddr;
    logic [32*NUM_FWD-1:0] fwd_wdata;
    logic [NUM_FWD-1:0]    fwd_is_load;
    logic                  id_ce;
    logic [31:0]           id_pc, id_inst, rs_val, rt_val;
    logic [4:0]            rs_addr, rt_addr;
    logic                  stallreq;
    logic [CNT_W-1:0]      stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    id_issue_stage #(.NUM_FWD(NUM_FWD), .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_ce(if_ce), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .use_rs(use_rs), .use_rt(use_rt), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .id_ce(id_ce), .id_pc(id_pc), .id_inst(id_inst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_val(rs_val), .rt_val(rt_val), .stallreq(stallreq), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic clr_fwd();
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
    endtask

    task automatic set_src(input int k, input logic [4:0] a, input logic [31:0] d, input logic ld);
        fwd_we[k]           = 1'b1;
        fwd_waddr[5*k +: 5] = a;
        fwd_wdata[32*k +: 32] = d;
        fwd_is_load[k]      = ld;
    endtask

    // Inputs change at posedge+1, checks happen at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; if_ce = 1'b0; if_pc = '0;
        inst_sram_rdata = 32'hDEADBEEF; use_rs = 1'b0; use_rt = 1'b0;
        rf_rdata1 = 32'h7777_7777; rf_rdata2 = 32'h8888_8888;
        clr_fwd();
        tick(); tick();
        #1;
        chk("rst_id_ce",     {31'd0, id_ce}, 32'd0);
        chk("rst_id_pc",     id_pc, 32'd0);
        chk("rst_id_inst",   id_inst, 32'd0);
        chk("rst_rs_val",    rs_val, 32'd0);
        chk("rst_stallreq",  {31'd0, stallreq}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        rst = 1'b1;

        // Straight-line flow
        if_ce = 1'b1; if_pc = 32'hBFC0_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            inst_sram_rdata = 32'h2400_0000 + i;
            if_pc = 32'hBFC0_0000 + 4 * (i + 1);
            #1;
            chk("flow_id_pc",   id_pc, 32'hBFC0_0000 + 4 * i);
            chk("flow_id_inst", id_inst, 32'h2400_0000 + i);
            chk("flow_stallreq", {31'd0, stallreq}, 32'd0);
            tick();
        end

        // ID now holds pc 0xBFC00010; instruction rs=r8, rt=r9
        if_pc = 32'hBFC0_0014;
        inst_sram_rdata = 32'h0109_0000;
        use_rs = 1'b1;
        set_src(0, 5'd8, 32'h1234, 1'b0);
        set_src(2, 5'd8, 32'h5555, 1'b0);
        #1;
        chk("rs_addr", {27'd0, rs_addr}, 32'd8);
        chk("fwd_ex_rs", rs_val, 32'h1234);
        chk("fwd_rt_rf", rt_val, 32'h8888_8888);
        fwd_we[0] = 1'b0;
        #1;
        chk("fwd_wb_rs", rs_val, 32'h5555);

        // Load-use on rt with a one-cycle stall
        clr_fwd(); use_rs = 1'b0; use_rt = 1'b1;
        set_src(0, 5'd9, 32'hBAD0_BAD0, 1'b1);
        stall = 6'b000110;
        #1;
        chk("lu_stallreq", {31'd0, stallreq}, 32'd1);
        tick();
        stall = '0; inst_sram_rdata = 32'hFFFF_0000;
        clr_fwd(); set_src(1, 5'd9, 32'hABCD, 1'b0);
        #1;
        chk("held_id_inst", id_inst, 32'h0109_0000);
        chk("held_id_pc",   id_pc, 32'hBFC0_0010);
        chk("mem_rt_val",   rt_val, 32'hABCD);
        chk("lu_cleared",   {31'd0, stallreq}, 32'd0);
        chk("cnt_one",      {28'd0, stall_cnt}, 32'd1);
        tick();
        // Buffer released; SRAM word visible again at pc 0xBFC00014
        inst_sram_rdata = 32'h0009_0000;  // rs=r0, rt=r9
        clr_fwd(); use_rs = 1'b1; use_rt = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) set_src(k, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        chk("adv_id_pc",   id_pc, 32'hBFC0_0014);
        chk("adv_id_inst", id_inst, 32'h0009_0000);
        chk("r0_rs_val",   rs_val, 32'd0);
        chk("r0_rt_rf",    rt_val, 32'h8888_8888);
        chk("r0_stallreq", {31'd0, stallreq}, 32'd0);

        // rs=rt=r10, single load hit raises one stallreq
        inst_sram_rdata = 32'h014A_0000;
        clr_fwd(); use_rs = 1'b1; use_rt = 1'b1;
        set_src(0, 5'd10, 32'h0A0A_0A0A, 1'b1);
        set_src(2, 5'd10, 32'h0C0C_0C0C, 1'b0);
        #1;
        chk("same_rs_val",  rs_val, 32'h0A0A_0A0A);
        chk("same_rt_val",  rt_val, 32'h0A0A_0A0A);
        chk("same_stallreq", {31'd0, stallreq}, 32'd1);
        // Younger non-load masks an older pending load
        clr_fwd();
        set_src(0, 5'd10, 32'h1111, 1'b0);
        set_src(1, 5'd10, 32'h2222, 1'b1);
        #1;
        chk("mask_rs_val",   rs_val, 32'h1111);
        chk("mask_stallreq", {31'd0, stallreq}, 32'd0);
        clr_fwd();
        set_src(0, 5'd10, 32'h0A0A_0A0A, 1'b1);
        tick();  // one more interlock cycle counted
        clr_fwd();
        #1;
        chk("cnt_two", {28'd0, stall_cnt}, 32'd2);

        // Bubble: IF stopped, ID free
        stall = 6'b000010;
        tick();
        #1;
        chk("bubble_id_ce",   {31'd0, id_ce}, 32'd0);
        chk("bubble_id_inst", id_inst, 32'd0);

        // Flush while HELD
        stall = '0; if_pc = 32'hBFC0_0100;
        tick();
        inst_sram_rdata = 32'h3C01_0001; stall = 6'b000110;
        tick();
        inst_sram_rdata = 32'h3C02_0002;
        #1;
        chk("hold_inst", id_inst, 32'h3C01_0001);
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = '0; if_pc = 32'hBFC0_0200;
        #1;
        chk("flush_id_ce",   {31'd0, id_ce}, 32'd0);
        chk("flush_id_inst", id_inst, 32'd0);
        tick();
        inst_sram_rdata = 32'h3C03_0003;
        #1;
        chk("post_flush_empty", id_inst, 32'h3C03_0003);

        // Saturation: rs=r10, EX load to r10 held for 20 cycles
        inst_sram_rdata = 32'h014A_0000; use_rs = 1'b1; use_rt = 1'b0;
        set_src(0, 5'd10, 32'h0, 1'b1);
        stall = 6'b000110;
        exp_cnt = 2;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
        end
        #1;
        chk("sat_cnt", {28'd0, stall_cnt}, exp_cnt);
        chk("sat_stallreq", {31'd0, stallreq}, 32'd1);

        // Asynchronous reset mid-cycle while HELD
        #2;
        rst = 1'b0;
        #1;
        chk("arst_id_ce",    {31'd0, id_ce}, 32'd0);
        chk("arst_id_pc",    id_pc, 32'd0);
        chk("arst_id_inst",  id_inst, 32'd0);
        chk("arst_rs_val",   rs_val, 32'd0);
        chk("arst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("arst_cnt",      {28'd0, stall_cnt}, 32'd0);
        clr_fwd(); stall = '0; if_pc = 32'hBFC0_0300;
        tick();
        rst = 1'b1;
        tick();
        inst_sram_rdata = 32'h2408_0042;
        #1;
        chk("arst_empty_inst", id_inst, 32'h2408_0042);
        chk("arst_pc_load",    id_pc, 32'hBFC0_0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
# id_issue_stage

Parametrised decode/issue stage front end for the 5-stage MIPS pipeline, sitting between IF and EX. It holds the IF→ID pipeline register and buffers the synchronous instruction-SRAM word across stalls. It resolves rs/rt operands through an N-source priority forwarding network and raises the load-use interlock `stallreq`. It also keeps a saturating count of interlock cycles for performance monitoring.

## Interface
Parameters:
- `NUM_FWD`, 3: forwarding sources, index 0 youngest (EX), then MEM, WB.
- `STALL_W`, 6: width of the `stall` bus.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  STALL_W  stage stall vector; bit1 = IF stop, bit2 = ID stop, 1 = Stop.
- `flush`  in  1  kill the ID-stage contents.
- `if_ce`  in  1  IF slot valid.
- `if_pc`  in  32  IF PC.
- `inst_sram_rdata`  in  32  synchronous SRAM word for the PC now entering ID.
- `use_rs`, `use_rt`  in  1 each  decoded operand-use flags for `id_inst`.
- `rf_rdata1`, `rf_rdata2`  in  32 each  regfile read data for rs/rt.
- `fwd_we`  in  NUM_FWD  per-source write enable.
- `fwd_waddr`  in  5*NUM_FWD  per-source destination; source k at [5k+4:5k].
- `fwd_wdata`  in  32*NUM_FWD  per-source result.
- `fwd_is_load`  in  NUM_FWD  per-source "result not yet available" (pending load).
- `id_ce`  out  1  ID slot valid.
- `id_pc`  out  32  ID PC.
- `id_inst`  out  32  ID instruction.
- `rs_addr`, `rt_addr`  out  5 each  `id_inst[25:21]` and `id_inst[20:16]`, driven to the regfile.
- `rs_val`, `rt_val`  out  32 each  forwarded operands.
- `stallreq`  out  1  load-use interlock request.
- `stall_cnt`  out  CNT_W  saturating interlock-cycle count.

## Operation
- ID register {ce, pc} is updated with this priority:
  - reset: cleared to 0.
  - flush: cleared to 0.
  - stall[1]=Stop and stall[2]=NoStop: bubble, cleared to 0.
  - stall[1]=NoStop: load {if_ce, if_pc}.
  - otherwise: hold.
- Instruction buffer has states EMPTY and HELD.
  - EMPTY: `id_inst` = `inst_sram_rdata`.
  - EMPTY → HELD when stall[2]=Stop and ce=1. `inst_sram_rdata` is captured into `inst_buf` that cycle.
  - HELD: `id_inst` = `inst_buf`. Further SRAM output is ignored.
  - HELD → EMPTY on the cycle stall[2]=NoStop (ID advances), on flush, or on reset.
  - When ce=0, `id_inst` is forced to 0 (nop).
- Forwarding, per operand with address `a`:
  - `a`=0 gives 0.
  - Otherwise the lowest index k with fwd_we[k] and fwd_waddr[k]=a supplies fwd_wdata[k].
  - If no source matches, the regfile data is used.
- Load-use interlock:
  - `stallreq` = ce & ((use_rs & hit_rs & load_rs) | (use_rt & hit_rt & load_rt)).
  - hit_x / load_x are the hit and `fwd_is_load` of the selected (highest-priority) source.
  - A non-load younger match masks an older pending load.
- `stall_cnt` increments by 1 each cycle `stallreq`=1. It saturates at all-ones and never wraps.

## Timing
- Reset values: id_ce=0, id_pc=0, id_inst=0, inst_buf=0, state EMPTY, stall_cnt=0. Hence rs_val=rt_val=0 and stallreq=0.
- id_ce/id_pc: one-cycle latency from IF.
- id_inst, rs_val, rt_val, stallreq: combinational from registered state plus same-cycle inputs. No added latency.
- The instruction appears in ID the cycle after its PC was presented to the SRAM.
- Flush together with stall: flush wins. The register and buffer are cleared.
- Stall and ID-advance in the same cycle cannot occur; stall[2] alone decides the buffer.
- Reset asserted mid-stall clears HELD immediately (asynchronous). The first post-reset cycle is EMPTY.
- Multiple sources matching the same register: the youngest wins, even when older sources also match.
- rs=rt with both used: a single hit drives both operands and raises one stallreq.

## Structure
- Shared package/defines: `IF_TO_ID_WD`, stall bit indices, `Stop`/`NoStop`, and an operand-select function (priority forward mux), reused by any later dual-issue ID.
- One natural sub-module: `fwd_sel`, a parametrised (NUM_FWD) priority forwarding mux. It returns data, hit and load, and is instantiated twice (rs, rt).
- Regfile stays outside this block.

## Test plan
- Straight-line flow: IF pc 0xBFC00000..0xBFC0000C with no stall → id_pc follows one cycle later, id_inst = SRAM word, stallreq=0.
- EX forward: EX writes r8=0x1234, WB writes r8=0x5555, ID uses rs=r8 → rs_val=0x1234.
- Load-use: EX is_load to r9, ID use_rt=1 with rt=r9 → stallreq=1. With stall[2:1]=11 for 1 cycle, inst_buf holds the original word while SRAM changes. Next cycle MEM is non-load r9=0xABCD → rt_val=0xABCD, stallreq=0, stall_cnt=1.
- Register 0: all sources write r0=0xFFFFFFFF, ID rs=r0 → rs_val=0, stallreq=0.
- Bubble and flush: stall[1]=1, stall[2]=0 → id_ce=0 and id_inst=0 next cycle. Flush during HELD → buffer EMPTY, id_ce=0.
- Saturation and reset: CNT_W=4 with 20 stall cycles → stall_cnt=15. Async rst low mid-cycle → all outputs 0 immediately.
